// File: rtl/multi_lane_car_counter.sv
// Multi-lane ultrasonic car detector/counter with a read-and-clear NIOS register map.
// Each lane calibrates a base distance, then debounces car arrivals with hysteresis.

module multi_lane_car_counter_lane #(
    parameter int DIST_W       = 32,
    parameter int COUNT_W      = 16,
    parameter int DEBOUNCE     = 3,
    parameter int THRESH_SHIFT = 1,
    parameter int HYST_SHIFT   = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               calibrate,
    input  logic [DIST_W-1:0]  distance,
    input  logic               distance_ready,
    input  logic               clear,
    output logic               car,
    output logic               calibrated,
    output logic [COUNT_W-1:0] count
);
    localparam int DB_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE + 1) : 1;

    typedef enum logic [1:0] {IDLE, CAL, RUN} state_t;
    state_t state, state_next;

    logic [DIST_W-1:0] base, thr;
    logic [DIST_W:0]   rel;
    logic [DB_W-1:0]   dbc;
    logic              evaluate, qualify, db_done, arrive;

    assign thr      = base >> THRESH_SHIFT;
    assign rel      = {1'b0, thr} + {1'b0, base >> HYST_SHIFT};
    assign evaluate = (state == RUN) && distance_ready && !calibrate;
    // The qualifying side flips with car state, which is what creates the hysteresis band.
    assign qualify  = car ? ({1'b0, distance} >= rel) : (distance < thr);
    assign db_done  = (dbc == DB_W'(DEBOUNCE - 1));
    assign arrive   = evaluate && qualify && db_done && !car;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (calibrate) state_next = CAL;
            CAL:     if (distance_ready && distance != '0) state_next = RUN;
            RUN:     if (calibrate) state_next = CAL;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        calibrated = (state == RUN);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            base <= '0;
            car  <= 1'b0;
            dbc  <= '0;
        end else begin
            if (state == CAL && distance_ready && distance != '0) base <= distance;
            if (state == RUN && calibrate) begin
                car <= 1'b0;
                dbc <= '0;
            end else if (evaluate) begin
                if (!qualify) begin
                    dbc <= '0;
                end else if (db_done) begin
                    car <= !car;
                    dbc <= '0;
                end else begin
                    dbc <= dbc + 1'b1;
                end
            end
        end
    end

    // A clear coinciding with an arrival leaves 1 so the arrival is not lost.
    always_ff @(posedge clk) begin
        if (reset)                    count <= '0;
        else if (clear)               count <= COUNT_W'(arrive);
        else if (arrive && count != '1) count <= count + 1'b1;
    end
endmodule

module multi_lane_car_counter #(
    parameter int          NUM_LANES    = 4,
    parameter int          DIST_W       = 32,
    parameter int          COUNT_W      = 16,
    parameter logic [15:0] BASE_ADDR    = 16'h0900,
    parameter int          DEBOUNCE     = 3,
    parameter int          THRESH_SHIFT = 1,
    parameter int          HYST_SHIFT   = 3
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_LANES-1:0]           calibrate,
    input  logic [NUM_LANES*DIST_W-1:0]    distance,
    input  logic [NUM_LANES-1:0]           distance_ready,
    input  logic [15:0]                    address,
    input  logic                           io_select,
    output logic [31:0]                    read_data,
    output logic [NUM_LANES-1:0]           car,
    output logic [NUM_LANES-1:0]           calibrated,
    output logic [NUM_LANES*COUNT_W-1:0]   car_count
);
    localparam logic [13:0] CAR_WORD = 14'(NUM_LANES);
    localparam logic [13:0] CAL_WORD = 14'(NUM_LANES + 1);

    logic [NUM_LANES-1:0][COUNT_W-1:0] cnt;
    logic [NUM_LANES-1:0]              lane_hit;
    logic [15:0]                       offset;
    logic [31:0]                       rd_next;

    assign offset    = address - BASE_ADDR;
    assign car_count = cnt;

    always_comb begin
        rd_next  = '0;
        lane_hit = '0;
        if (offset[1:0] == 2'b00) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                if (offset[15:2] == 14'(i)) begin
                    rd_next[COUNT_W-1:0] = cnt[i];
                    lane_hit[i]          = 1'b1;
                end
            end
            if (offset[15:2] == CAR_WORD) rd_next[NUM_LANES-1:0] = car;
            if (offset[15:2] == CAL_WORD) rd_next[NUM_LANES-1:0] = calibrated;
        end
    end

    always_ff @(posedge clk) begin
        if (reset)          read_data <= '0;
        else if (io_select) read_data <= rd_next;
    end

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        multi_lane_car_counter_lane #(
            .DIST_W      (DIST_W),
            .COUNT_W     (COUNT_W),
            .DEBOUNCE    (DEBOUNCE),
            .THRESH_SHIFT(THRESH_SHIFT),
            .HYST_SHIFT  (HYST_SHIFT)
        ) u_lane (
            .clk           (clk),
            .reset         (reset),
            .calibrate     (calibrate[i]),
            .distance      (distance[i*DIST_W +: DIST_W]),
            .distance_ready(distance_ready[i]),
            .clear         (io_select && lane_hit[i]),
            .car           (car[i]),
            .calibrated    (calibrated[i]),
            .count         (cnt[i])
        );
    end
endmodule

// File: tb/tb_multi_lane_car_counter.sv
// Directed bench for multi_lane_car_counter: register reads go through an expected-value queue.
module tb_multi_lane_car_counter;
    localparam int NUM_LANES = 4;
    localparam int DIST_W    = 32;
    localparam int COUNT_W   = 4;

    logic                         clk = 1'b0;
    logic                         reset;
    logic [NUM_LANES-1:0]         calibrate;
    logic [NUM_LANES*DIST_W-1:0]  distance;
    logic [NUM_LANES-1:0]         distance_ready;
    logic [15:0]                  address;
    logic                         io_select;
    logic [31:0]                  read_data;
    logic [NUM_LANES-1:0]         car;
    logic [NUM_LANES-1:0]         calibrated;
    logic [NUM_LANES*COUNT_W-1:0] car_count;

    int          nvec = 0;
    int          nerr = 0;
    logic [31:0] exp_q[$];

    multi_lane_car_counter #(
        .NUM_LANES(NUM_LANES), .DIST_W(DIST_W), .COUNT_W(COUNT_W), .BASE_ADDR(16'h0900),
        .DEBOUNCE(3), .THRESH_SHIFT(1), .HYST_SHIFT(3)
    ) dut (
        .clk(clk), .reset(reset), .calibrate(calibrate), .distance(distance),
        .distance_ready(distance_ready), .address(address), .io_select(io_select),
        .read_data(read_data), .car(car), .calibrated(calibrated), .car_count(car_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] cnt_of(input int ln);
        return 32'(car_count[ln*COUNT_W +: COUNT_W]);
    endfunction

    task automatic samp(input int ln, input logic [31:0] v);
        distance[ln*DIST_W +: DIST_W] = v;
        distance_ready[ln] = 1'b1;
        tick();
        distance_ready[ln] = 1'b0;
    endtask

    task automatic arrive(input int ln);
        repeat (3) samp(ln, 400);
        repeat (3) samp(ln, 700);
    endtask

    task automatic cal_lane(input int ln);
        calibrate[ln] = 1'b1;
        tick();
        calibrate[ln] = 1'b0;
        samp(ln, 1000);
    endtask

    task automatic pop_chk(input string tag);
        logic [31:0] e;
        if (exp_q.size() == 0) begin
            chk({tag, "_queue_empty"}, 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            chk(tag, read_data, e);
        end
    endtask

    task automatic rd(input string tag, input logic [15:0] a, input logic [31:0] e);
        address   = a;
        io_select = 1'b1;
        exp_q.push_back(e);
        tick();
        io_select = 1'b0;
        pop_chk(tag);
    endtask

    initial begin
        reset = 1'b1; calibrate = '0; distance = '0; distance_ready = '0;
        address = '0; io_select = 1'b0;
        tick(); tick();
        chk("rst_calibrated", 32'(calibrated), 32'h0);
        chk("rst_car", 32'(car), 32'h0);
        chk("rst_count", 32'(car_count), 32'h0);
        chk("rst_read_data", read_data, 32'h0);
        reset = 1'b0;
        tick();

        // Lane 0 calibration: zero sample ignored, 1000 gives thr=500 rel=625
        calibrate[0] = 1'b1; tick(); calibrate[0] = 1'b0;
        chk("cal_pending", 32'(calibrated), 32'h0);
        samp(0, 0);
        chk("cal_zero_sample", 32'(calibrated), 32'h0);
        samp(0, 1000);
        chk("cal_done", 32'(calibrated), 32'h1);

        // 500 == thr does not qualify; idle cycles do not break the run
        samp(0, 500); samp(0, 400); samp(0, 400);
        chk("car_two_low", 32'(car), 32'h0);
        tick(); tick();
        samp(0, 400);
        chk("car_set", 32'(car), 32'h1);
        chk("count_first", cnt_of(0), 32'd1);
        repeat (3) samp(0, 600);
        chk("car_hyst_hold", 32'(car), 32'h1);
        samp(0, 625); samp(0, 700);
        chk("car_two_high", 32'(car), 32'h1);
        samp(0, 700);
        chk("car_clear", 32'(car), 32'h0);
        chk("count_after_leave", cnt_of(0), 32'd1);
        rd("read_lane0", 16'h0900, 32'd1);
        chk("count_cleared", cnt_of(0), 32'd0);

        samp(0, 400); samp(0, 400); samp(0, 800); samp(0, 400); samp(0, 400);
        chk("debounce_broken_car", 32'(car), 32'h0);
        chk("debounce_broken_cnt", cnt_of(0), 32'd0);
        samp(0, 700);
        repeat (5) arrive(0);
        chk("count_five", cnt_of(0), 32'd5);

        // Read coinciding with the arrival edge
        samp(0, 400); samp(0, 400);
        distance[0 +: DIST_W] = 400; distance_ready[0] = 1'b1;
        address = 16'h0900; io_select = 1'b1;
        exp_q.push_back(32'd5);
        tick();
        distance_ready[0] = 1'b0; io_select = 1'b0;
        pop_chk("read_coincident");
        chk("count_coincident", cnt_of(0), 32'd1);
        chk("car_coincident", 32'(car), 32'h1);
        repeat (3) samp(0, 700);

        // Lane 2 saturation at 4 bits
        cal_lane(2);
        repeat (17) arrive(2);
        chk("count2_sat", cnt_of(2), 32'd15);
        rd("read_lane2_sat", 16'h0908, 32'd15);
        chk("count2_cleared", cnt_of(2), 32'd0);

        // Lane 1 car present, bitmask registers
        cal_lane(1);
        repeat (3) samp(1, 400);
        chk("lane1_car", 32'(car), 32'h2);
        chk("lane1_count", cnt_of(1), 32'd1);
        rd("read_car_mask", 16'h0910, 32'h2);
        chk("car_mask_no_side_effect", cnt_of(1), 32'd1);
        rd("read_cal_mask", 16'h0914, 32'h7);
        rd("read_unmapped", 16'h0918, 32'h0);
        rd("read_misaligned", 16'h0902, 32'h0);
        rd("read_below_base", 16'h08fc, 32'h0);

        calibrate[1] = 1'b1; tick(); calibrate[1] = 1'b0;
        chk("recal_car", 32'(car), 32'h0);
        chk("recal_calibrated", 32'(calibrated), 32'h5);
        chk("recal_count_kept", cnt_of(1), 32'd1);
        rd("read_lane1", 16'h0904, 32'd1);
        chk("read_data_hold", read_data, 32'd1);

        // Reset during a read wins
        address = 16'h0900; io_select = 1'b1; reset = 1'b1;
        tick();
        io_select = 1'b0; reset = 1'b0;
        chk("rst_mid_read_data", read_data, 32'h0);
        chk("rst_mid_read_count", 32'(car_count), 32'h0);
        chk("rst_mid_read_cal", 32'(calibrated), 32'h0);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
